// File: rtl/frame_writer_pkg.sv
// Shared definitions for the frame writer and the switch requester: destination width,
// frame buffer / sideband word layouts and the writer state encoding.
package frame_writer_pkg;

  localparam int AXIS_DEST_WIDTH = 4;

  localparam int FW_WIDTH      = 20;
  localparam int FW_DATA_WIDTH = 16;
  localparam int FW_LAST_BIT   = 16;

  // Sideband entry: {zero pad, end_ptr, dest}; the requester decodes with the same offsets
  localparam int SB_WIDTH    = 20;
  localparam int SB_DEST_LSB = 0;
  localparam int SB_PTR_LSB  = AXIS_DEST_WIDTH;

  localparam logic [2:0] ST_IDLE_ENC    = 3'd0;
  localparam logic [2:0] ST_HEADER_ENC  = 3'd1;
  localparam logic [2:0] ST_AWAIT_ENC   = 3'd2;
  localparam logic [2:0] ST_PAYLOAD_ENC = 3'd3;
  localparam logic [2:0] ST_COMMIT_ENC  = 3'd4;
  localparam logic [2:0] ST_DRAIN_ENC   = 3'd5;
  localparam logic [2:0] ST_REWIND_ENC  = 3'd6;

  typedef enum logic [2:0] {
    ST_IDLE    = ST_IDLE_ENC,
    ST_HEADER  = ST_HEADER_ENC,
    ST_AWAIT   = ST_AWAIT_ENC,
    ST_PAYLOAD = ST_PAYLOAD_ENC,
    ST_COMMIT  = ST_COMMIT_ENC,
    ST_DRAIN   = ST_DRAIN_ENC,
    ST_REWIND  = ST_REWIND_ENC
  } fw_state_t;

  function automatic logic [FW_WIDTH-1:0] pack_frame_word(input logic last,
                                                          input logic [FW_DATA_WIDTH-1:0] data);
    logic [FW_WIDTH-1:0] w;
    w = {FW_WIDTH{1'b0}};
    w[FW_DATA_WIDTH-1:0] = data;
    w[FW_LAST_BIT] = last;
    return w;
  endfunction

endpackage

// File: rtl/frame_writer_stats.sv
// Saturating committed/dropped frame counters for frame_writer.
// Only compiled when FRAME_WRITER_STATS_EN is defined.
`ifdef FRAME_WRITER_STATS_EN
module frame_writer_stats (
  input  logic        clk,
  input  logic        reset,
  input  logic        stat_clear,
  input  logic        inc_committed,
  input  logic        inc_dropped,
  output logic [15:0] stat_committed,
  output logic [15:0] stat_dropped
);

  // Clear wins over a same-cycle increment; counters stick at all-ones
  always_ff @(posedge clk) begin
    if (reset || stat_clear) begin
      stat_committed <= 16'd0;
      stat_dropped   <= 16'd0;
    end else begin
      if (inc_committed && (stat_committed != 16'hFFFF)) begin
        stat_committed <= stat_committed + 16'd1;
      end
      if (inc_dropped && (stat_dropped != 16'hFFFF)) begin
        stat_dropped <= stat_dropped + 16'd1;
      end
    end
  end

endmodule
`endif

// File: rtl/frame_writer.sv
// Ingress frame writer: streams AXIS words into the frame buffer, then commits (sideband push)
// or rewinds on the filter verdict. Optional counters under FRAME_WRITER_STATS_EN.
module frame_writer
  import frame_writer_pkg::*;
#(
  parameter int ADDR_WIDTH      = 11,
  parameter int MAX_FRAME_WORDS = 1024
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [15:0]                ingress_tdata,
  input  logic                       ingress_tvalid,
  input  logic                       ingress_tlast,
  output logic                       ingress_tready,
  input  logic                       decision_valid,
  input  logic                       decision_drop,
  input  logic [AXIS_DEST_WIDTH-1:0] decision_dest,
  output logic                       scan_payload,
  output logic                       frame_wen,
  output logic [FW_WIDTH-1:0]        frame_wdata,
  input  logic [ADDR_WIDTH:0]        frame_wptr,
  input  logic                       frame_full,
  output logic                       frame_wrst,
  output logic [ADDR_WIDTH:0]        frame_rst_wptr,
  output logic                       sideband_wen,
  output logic [SB_WIDTH-1:0]        sideband_wdata,
  input  logic                       sideband_full,
  output logic                       dropped
`ifdef FRAME_WRITER_STATS_EN
  ,
  input  logic                       stat_clear,
  output logic [15:0]                stat_committed,
  output logic [15:0]                stat_dropped
`endif
);

  localparam int PTR_W = ADDR_WIDTH + 1;
  localparam int CNT_W = $clog2(MAX_FRAME_WORDS) + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_FRAME_WORDS);

  if (PTR_W + AXIS_DEST_WIDTH > SB_WIDTH) begin : g_width_check
    $error("frame_writer: end pointer plus dest does not fit the sideband entry");
  end

  fw_state_t                  state, state_next;
  logic                       settled, settled_next;
  logic [CNT_W-1:0]           count, count_next, count_inc;
  logic [AXIS_DEST_WIDTH-1:0] dest_latched, dest_next;
  logic [PTR_W-1:0]           rst_wptr_next;
  logic                       wen_next, sb_wen_next, wrst_next, dropped_next, scan_next;
  logic [FW_WIDTH-1:0]        wdata_next;
  logic [SB_WIDTH-1:0]        sb_wdata_next, sb_word;
  logic                       accept, oversize;

  // Ingress handshake; DRAIN swallows words even when the buffer is full
  always_comb begin
    ingress_tready = 1'b0;
    if (reset) begin
      ingress_tready = 1'b0;
    end else if (state == ST_DRAIN) begin
      ingress_tready = 1'b1;
    end else if ((state == ST_IDLE) || (state == ST_HEADER) || (state == ST_PAYLOAD)) begin
      ingress_tready = ~frame_full;
    end else begin
      ingress_tready = 1'b0;
    end
    accept    = ingress_tvalid & ingress_tready;
    count_inc = (&count) ? count : count + CNT_W'(1);
    oversize  = (count_inc >= CNT_MAX) & ~ingress_tlast;
  end

  // Next-state and next-output decode
  always_comb begin
    state_next    = state;
    settled_next  = 1'b0;
    count_next    = count;
    dest_next     = dest_latched;
    rst_wptr_next = frame_rst_wptr;
    wen_next      = 1'b0;
    wdata_next    = frame_wdata;
    sb_wen_next   = 1'b0;
    sb_wdata_next = sideband_wdata;
    sb_word       = {SB_WIDTH{1'b0}};
    sb_word[SB_PTR_LSB +: PTR_W]            = frame_wptr;
    sb_word[SB_DEST_LSB +: AXIS_DEST_WIDTH] = dest_latched;

    case (state)
      ST_IDLE: begin
        if (accept) begin
          rst_wptr_next = frame_wptr;
          count_next    = CNT_W'(1);
          wen_next      = 1'b1;
          wdata_next    = pack_frame_word(ingress_tlast, ingress_tdata);
          state_next    = ingress_tlast ? ST_AWAIT : ST_HEADER;
        end else begin
          state_next = ST_IDLE;
        end
      end
      ST_HEADER: begin
        if (decision_valid && decision_drop) begin
          // the word accepted alongside a drop verdict is already discarded
          if (accept) begin
            count_next = count_inc;
            state_next = ingress_tlast ? ST_REWIND : ST_DRAIN;
          end else begin
            state_next = ST_DRAIN;
          end
        end else begin
          if (decision_valid) begin
            dest_next = decision_dest;
          end else begin
            dest_next = dest_latched;
          end
          if (accept) begin
            count_next = count_inc;
            wen_next   = 1'b1;
            wdata_next = pack_frame_word(ingress_tlast, ingress_tdata);
          end else begin
            count_next = count;
          end
          if (accept && ingress_tlast) begin
            state_next = decision_valid ? ST_COMMIT : ST_AWAIT;
          end else if (accept && oversize) begin
            state_next = ST_DRAIN;
          end else if (decision_valid) begin
            state_next = ST_PAYLOAD;
          end else begin
            state_next = ST_HEADER;
          end
        end
      end
      ST_AWAIT: begin
        if (decision_valid) begin
          dest_next  = decision_drop ? dest_latched : decision_dest;
          state_next = decision_drop ? ST_REWIND : ST_COMMIT;
        end else begin
          state_next = ST_AWAIT;
        end
      end
      ST_PAYLOAD: begin
        if (accept) begin
          count_next = count_inc;
          wen_next   = 1'b1;
          wdata_next = pack_frame_word(ingress_tlast, ingress_tdata);
          if (ingress_tlast) begin
            state_next = ST_COMMIT;
          end else if (oversize) begin
            state_next = ST_DRAIN;
          end else begin
            state_next = ST_PAYLOAD;
          end
        end else begin
          state_next = ST_PAYLOAD;
        end
      end
      ST_COMMIT: begin
        // first cycle lets the last frame write land so frame_wptr is the end pointer
        if (!settled) begin
          settled_next = 1'b1;
        end else if (!sideband_full) begin
          sb_wen_next   = 1'b1;
          sb_wdata_next = sb_word;
          state_next    = ST_IDLE;
        end else begin
          settled_next = 1'b1;
        end
      end
      ST_DRAIN: begin
        if (accept) begin
          count_next = count_inc;
          state_next = ingress_tlast ? ST_REWIND : ST_DRAIN;
        end else begin
          state_next = ST_DRAIN;
        end
      end
      ST_REWIND: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase

    wrst_next    = (state_next == ST_REWIND);
    dropped_next = (state_next == ST_REWIND);
    scan_next    = (state_next == ST_PAYLOAD);
  end

  // State, frame bookkeeping and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= ST_IDLE;
      settled        <= 1'b0;
      count          <= {CNT_W{1'b0}};
      dest_latched   <= {AXIS_DEST_WIDTH{1'b0}};
      frame_rst_wptr <= {PTR_W{1'b0}};
      frame_wen      <= 1'b0;
      frame_wdata    <= {FW_WIDTH{1'b0}};
      sideband_wen   <= 1'b0;
      sideband_wdata <= {SB_WIDTH{1'b0}};
      frame_wrst     <= 1'b0;
      dropped        <= 1'b0;
      scan_payload   <= 1'b0;
    end else begin
      state          <= state_next;
      settled        <= settled_next;
      count          <= count_next;
      dest_latched   <= dest_next;
      frame_rst_wptr <= rst_wptr_next;
      frame_wen      <= wen_next;
      frame_wdata    <= wdata_next;
      sideband_wen   <= sb_wen_next;
      sideband_wdata <= sb_wdata_next;
      frame_wrst     <= wrst_next;
      dropped        <= dropped_next;
      scan_payload   <= scan_next;
    end
  end

`ifdef FRAME_WRITER_STATS_EN
  frame_writer_stats u_stats (
    .clk            (clk),
    .reset          (reset),
    .stat_clear     (stat_clear),
    .inc_committed  (sideband_wen),
    .inc_dropped    (dropped),
    .stat_committed (stat_committed),
    .stat_dropped   (stat_dropped)
  );
`endif

endmodule

// File: tb/tb_frame_writer.sv
// Directed self-checking bench for frame_writer (MAX_FRAME_WORDS=8 so oversize is reachable).
`timescale 1ns/1ps
module tb_frame_writer;
  import frame_writer_pkg::*;

  localparam int PW = 12;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic [15:0] ingress_tdata;
  logic        ingress_tvalid, ingress_tlast, ingress_tready;
  logic        decision_valid, decision_drop;
  logic [3:0]  decision_dest;
  logic        scan_payload, frame_wen, frame_full, frame_wrst;
  logic [19:0] frame_wdata, sideband_wdata;
  logic [PW-1:0] frame_wptr, frame_rst_wptr;
  logic        sideband_wen, sideband_full, dropped;
`ifdef FRAME_WRITER_STATS_EN
  logic        stat_clear;
  logic [15:0] stat_committed, stat_dropped;
`endif

  frame_writer #(.ADDR_WIDTH(11), .MAX_FRAME_WORDS(8)) dut (
    .clk(clk), .reset(reset),
    .ingress_tdata(ingress_tdata), .ingress_tvalid(ingress_tvalid),
    .ingress_tlast(ingress_tlast), .ingress_tready(ingress_tready),
    .decision_valid(decision_valid), .decision_drop(decision_drop),
    .decision_dest(decision_dest), .scan_payload(scan_payload),
    .frame_wen(frame_wen), .frame_wdata(frame_wdata), .frame_wptr(frame_wptr),
    .frame_full(frame_full), .frame_wrst(frame_wrst), .frame_rst_wptr(frame_rst_wptr),
    .sideband_wen(sideband_wen), .sideband_wdata(sideband_wdata),
    .sideband_full(sideband_full), .dropped(dropped)
`ifdef FRAME_WRITER_STATS_EN
    , .stat_clear(stat_clear), .stat_committed(stat_committed), .stat_dropped(stat_dropped)
`endif
  );

  // Frame buffer write pointer model
  logic          ptr_load;
  logic [PW-1:0] ptr_val, fb_wptr;
  assign frame_wptr = fb_wptr;
  always @(posedge clk) begin
    if (ptr_load) fb_wptr <= ptr_val;
    else if (frame_wrst) fb_wptr <= frame_rst_wptr;
    else if (frame_wen) fb_wptr <= fb_wptr + 12'd1;
  end

  // Output event monitor
  int cnt_wen = 0, cnt_sb = 0, cnt_wrst = 0, cnt_drop = 0;
  logic [19:0]   last_fdata = 20'd0, last_sbdata = 20'd0;
  logic [PW-1:0] last_rstptr = 12'd0;
  always @(negedge clk) begin
    if (frame_wen) begin cnt_wen <= cnt_wen + 1; last_fdata <= frame_wdata; end
    if (sideband_wen) begin cnt_sb <= cnt_sb + 1; last_sbdata <= sideband_wdata; end
    if (frame_wrst) begin cnt_wrst <= cnt_wrst + 1; last_rstptr <= frame_rst_wptr; end
    if (dropped) cnt_drop <= cnt_drop + 1;
  end

  int n_checks = 0, n_fails = 0;
  int b_wen, b_sb, b_wrst, b_drop;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic snap();
    b_wen = cnt_wen; b_sb = cnt_sb; b_wrst = cnt_wrst; b_drop = cnt_drop;
  endtask

  task automatic set_ptr(input logic [PW-1:0] v);
    ptr_val = v; ptr_load = 1'b1;
    tick();
    ptr_load = 1'b0;
  endtask

  task automatic xfer(input logic [15:0] d, input logic l, input logic dv,
                      input logic dd, input logic [3:0] dst);
    int n;
    n = 0;
    ingress_tdata = d; ingress_tlast = l; ingress_tvalid = 1'b1;
    decision_valid = dv; decision_drop = dd; decision_dest = dst;
    @(negedge clk);
    while (!ingress_tready && n < 50) begin
      tick();
      decision_valid = 1'b0;
      n++;
      @(negedge clk);
    end
    tick();
    ingress_tvalid = 1'b0; ingress_tlast = 1'b0; decision_valid = 1'b0;
    chk("xfer_accept", {31'd0, n < 50}, 32'd1);
  endtask

  task automatic wait_push(input string tag);
    int n;
    n = 0;
    while (cnt_sb == b_sb && n < 30) begin tick(); n++; end
    chk(tag, cnt_sb - b_sb, 32'd1);
  endtask

  task automatic wait_drop(input string tag);
    int n;
    n = 0;
    while (cnt_drop == b_drop && n < 30) begin tick(); n++; end
    chk(tag, cnt_drop - b_drop, 32'd1);
  endtask

  initial begin
    reset = 1'b1; ingress_tdata = 16'd0; ingress_tvalid = 1'b0; ingress_tlast = 1'b0;
    decision_valid = 1'b0; decision_drop = 1'b0; decision_dest = 4'd0;
    frame_full = 1'b0; sideband_full = 1'b0; ptr_load = 1'b1; ptr_val = 12'd0;
`ifdef FRAME_WRITER_STATS_EN
    stat_clear = 1'b0;
`endif
    repeat (3) tick();
    @(negedge clk);
    chk("rst_tready", {31'd0, ingress_tready}, 32'd0);
    chk("rst_outputs", {26'd0, frame_wen, sideband_wen, frame_wrst, dropped, scan_payload, 1'b0}, 32'd0);
    chk("rst_rst_wptr", {20'd0, frame_rst_wptr}, 32'd0);
    chk("rst_wdata", {12'd0, frame_wdata}, 32'd0);
    tick();
    reset = 1'b0; ptr_load = 1'b0;

    // Accepted frame at 0x010, decision at word 2
    set_ptr(12'h010); snap();
    xfer(16'hA000, 1'b0, 1'b0, 1'b0, 4'd0);
    xfer(16'hA001, 1'b0, 1'b0, 1'b0, 4'd0);
    chk("acc_scan_header", {31'd0, scan_payload}, 32'd0);
    xfer(16'hA002, 1'b0, 1'b1, 1'b0, 4'd3);
    chk("acc_scan_after_dec", {31'd0, scan_payload}, 32'd1);
    xfer(16'hA003, 1'b0, 1'b0, 1'b0, 4'd0);
    chk("acc_scan_payload", {31'd0, scan_payload}, 32'd1);
    xfer(16'hA004, 1'b1, 1'b0, 1'b0, 4'd0);
    chk("acc_scan_commit", {31'd0, scan_payload}, 32'd0);
    wait_push("acc_push");
    chk("acc_sb_data", {12'd0, last_sbdata}, 32'h00153);
    chk("acc_wen_count", cnt_wen - b_wen, 32'd5);
    chk("acc_last_word", {12'd0, last_fdata}, 32'h1A004);
    chk("acc_rst_wptr", {20'd0, frame_rst_wptr}, 32'h010);

    // Early drop of an 8-word frame at 0x020
    set_ptr(12'h020); snap();
    xfer(16'hB000, 1'b0, 1'b0, 1'b0, 4'd0);
    xfer(16'hB001, 1'b0, 1'b1, 1'b1, 4'd7);
    for (int i = 2; i < 8; i++) xfer(16'hB000 + 16'(i), (i == 7), 1'b0, 1'b0, 4'd0);
    wait_drop("drop_pulse");
    chk("drop_wen_count", cnt_wen - b_wen, 32'd1);
    chk("drop_written_word", {12'd0, last_fdata}, 32'h0B000);
    chk("drop_wrst_count", cnt_wrst - b_wrst, 32'd1);
    chk("drop_rst_wptr", {20'd0, last_rstptr}, 32'h020);
    chk("drop_no_push", cnt_sb - b_sb, 32'd0);

    // Late decision: 3-word frame then 4 idle cycles in AWAIT
    set_ptr(12'h100); snap();
    xfer(16'hC000, 1'b0, 1'b0, 1'b0, 4'd0);
    xfer(16'hC001, 1'b0, 1'b0, 1'b0, 4'd0);
    xfer(16'hC002, 1'b1, 1'b0, 1'b0, 4'd0);
    ingress_tvalid = 1'b1; ingress_tdata = 16'hCCCC;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("await_tready", {31'd0, ingress_tready}, 32'd0);
      tick();
    end
    ingress_tvalid = 1'b0;
    chk("await_no_push", cnt_sb - b_sb, 32'd0);
    decision_valid = 1'b1; decision_drop = 1'b0; decision_dest = 4'd5;
    tick();
    decision_valid = 1'b0;
    wait_push("late_push");
    chk("late_sb_data", {12'd0, last_sbdata}, 32'h01035);
    chk("late_wen_count", cnt_wen - b_wen, 32'd3);

    // Sideband backpressure held 6 cycles at COMMIT
    set_ptr(12'h200); snap();
    sideband_full = 1'b1;
    xfer(16'hD000, 1'b0, 1'b0, 1'b0, 4'd0);
    xfer(16'hD001, 1'b0, 1'b1, 1'b0, 4'd6);
    xfer(16'hD002, 1'b1, 1'b0, 1'b0, 4'd0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("bp_tready", {31'd0, ingress_tready}, 32'd0);
      tick();
    end
    chk("bp_no_push", cnt_sb - b_sb, 32'd0);
    sideband_full = 1'b0;
    tick();
    chk("bp_push_timing", {31'd0, sideband_wen}, 32'd1);
    chk("bp_sb_data", {12'd0, sideband_wdata}, 32'h02036);

    // Pointer wrap: 4 words from 0x7FE end at 0x802
    set_ptr(12'h7FE); snap();
    xfer(16'hF000, 1'b0, 1'b0, 1'b0, 4'd0);
    xfer(16'hF001, 1'b0, 1'b1, 1'b0, 4'd9);
    xfer(16'hF002, 1'b0, 1'b0, 1'b0, 4'd0);
    xfer(16'hF003, 1'b1, 1'b0, 1'b0, 4'd0);
    wait_push("wrap_push");
    chk("wrap_sb_data", {12'd0, last_sbdata}, 32'h08029);
    chk("wrap_wen_count", cnt_wen - b_wen, 32'd4);

    // Oversize: 12 words with limit 8, with a frame_full stall and a full buffer during drain
    set_ptr(12'h300); snap();
    for (int i = 0; i < 12; i++) begin
      if (i == 3) begin
        frame_full = 1'b1;
        @(negedge clk);
        chk("full_stall_tready", {31'd0, ingress_tready}, 32'd0);
        tick();
        frame_full = 1'b0;
      end
      if (i == 8) frame_full = 1'b1;
      xfer(16'h6000 + 16'(i), (i == 11), 1'b0, 1'b0, 4'd0);
    end
    frame_full = 1'b0;
    wait_drop("ovs_drop");
    chk("ovs_wen_count", cnt_wen - b_wen, 32'd8);
    chk("ovs_last_word", {12'd0, last_fdata}, 32'h06007);
    chk("ovs_wrst_count", cnt_wrst - b_wrst, 32'd1);
    chk("ovs_rst_wptr", {20'd0, last_rstptr}, 32'h300);
    chk("ovs_no_push", cnt_sb - b_sb, 32'd0);

    // Reset during PAYLOAD
    set_ptr(12'h400);
    xfer(16'h7000, 1'b0, 1'b0, 1'b0, 4'd0);
    xfer(16'h7001, 1'b0, 1'b1, 1'b0, 4'd2);
    xfer(16'h7002, 1'b0, 1'b0, 1'b0, 4'd0);
    chk("mid_scan", {31'd0, scan_payload}, 32'd1);
    chk("mid_wen", {31'd0, frame_wen}, 32'd1);
    ingress_tvalid = 1'b1; ingress_tdata = 16'h7003; reset = 1'b1;
    tick();
    chk("mrst_outputs", {26'd0, frame_wen, sideband_wen, frame_wrst, dropped, scan_payload, ingress_tready}, 32'd0);
    chk("mrst_rst_wptr", {20'd0, frame_rst_wptr}, 32'd0);
    chk("mrst_wdata", {12'd0, frame_wdata}, 32'd0);
    ingress_tvalid = 1'b0; reset = 1'b0;
    snap();
    repeat (10) tick();
    chk("mrst_no_push", cnt_sb - b_sb, 32'd0);
    chk("mrst_no_wrst", cnt_wrst - b_wrst, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/frame_writer.md
Name: frame_writer

Overview:
- Ingress-side producer for the frame buffer and sideband FIFO; the writing end of the interface drained by the switch requester.
- Accepts a 16-bit AXIS word stream and writes every word into the frame buffer.
- Holds the frame until a filter decision arrives, then either commits it or rewinds the frame buffer write pointer.
- On commit, pushes a sideband entry {end pointer, tdest} and drives scan_payload so the requester can start early.

Parameters:
- ADDR_WIDTH, 11, frame buffer address width; pointers are ADDR_WIDTH+1 bits, MSB is the wrap bit.
- MAX_FRAME_WORDS, 1024, word count at which a frame is force-dropped as oversize.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- ingress_tdata  in  16  ingress word
- ingress_tvalid  in  1  ingress word valid
- ingress_tlast  in  1  last word of frame
- ingress_tready  out  1  ingress ready
- decision_valid  in  1  one-cycle filter verdict strobe
- decision_drop  in  1  1 = discard current frame
- decision_dest  in  AXIS_DEST_WIDTH  egress destination
- scan_payload  out  1  current frame accepted and still streaming
- frame_wen  out  1  frame buffer write enable
- frame_wdata  out  20  {3'b0, last, data[15:0]}
- frame_wptr  in  ADDR_WIDTH+1  buffer write pointer after the pending write
- frame_full  in  1  frame buffer full
- frame_wrst  out  1  one-cycle pulse: load write pointer from frame_rst_wptr
- frame_rst_wptr  out  ADDR_WIDTH+1  frame start pointer for rewind
- sideband_wen  out  1  sideband push
- sideband_wdata  out  20  {zero pad, end_ptr[ADDR_WIDTH:0], dest[AXIS_DEST_WIDTH-1:0]}
- sideband_full  in  1  sideband FIFO full
- dropped  out  1  one-cycle pulse per discarded frame

Behaviour:
- Reset values: all outputs 0; state IDLE; frame_rst_wptr 0; latched dest 0; word count 0.
- Handshake: a word is accepted when ingress_tvalid & ingress_tready.
  - ingress_tready = (state in {IDLE, HEADER, PAYLOAD, DRAIN}) & ~frame_full; in DRAIN, frame_full is ignored.
  - frame_wen is registered: it is asserted on the cycle after acceptance, with frame_wdata = {3'b0, tlast, tdata}. Latency is 1 cycle.
- States:
  - IDLE: on the first accepted word, latch frame_rst_wptr = frame_wptr, set count = 1, go to HEADER.
  - HEADER: accept words.
    - decision_valid with drop=0: latch dest; go to PAYLOAD; scan_payload becomes 1 on the next cycle.
    - decision_valid with drop=1: go to DRAIN.
    - tlast accepted before any decision: go to AWAIT.
  - AWAIT: tready = 0.
    - decision_valid with drop=0: go to COMMIT.
    - decision_valid with drop=1: go to REWIND.
  - PAYLOAD: scan_payload = 1; accept words; on tlast accepted, go to COMMIT.
  - COMMIT: tready = 0; scan_payload = 0.
    - Wait one cycle for the final write to retire, then wait for ~sideband_full.
    - Pulse sideband_wen with end_ptr = frame_wptr and the latched dest; go to IDLE.
  - DRAIN: accept and discard words (no frame_wen); on tlast accepted, go to REWIND.
  - REWIND: pulse frame_wrst and dropped; go to IDLE on the next cycle.
- Simultaneous decision_valid and tlast in HEADER:
  - drop=0: the decision is taken and the state goes directly to COMMIT.
  - drop=1: the state goes to REWIND.
- decision_valid outside HEADER/AWAIT is ignored.
- Oversize: when count reaches MAX_FRAME_WORDS without tlast, go to DRAIN. A pending commit is never issued for that frame.
- frame_full mid-frame for more than 0 cycles stalls ingress only; it never drops. An oversize frame resolves via the MAX_FRAME_WORDS rule.
- Width: count is $clog2(MAX_FRAME_WORDS)+1 bits and saturates.
- Elaboration check: ADDR_WIDTH+1+AXIS_DEST_WIDTH <= 20.
- Pointer wrap: pointers are compared and stored as full ADDR_WIDTH+1 bits; the wrap bit is carried unchanged into end_ptr.
- Reset mid-frame: return to IDLE with all pulses cleared; no sideband push and no rewind are issued.

Optional Feature:
- Macro: FRAME_WRITER_STATS_EN.
- Defined:
  - Adds outputs stat_committed[15:0] and stat_dropped[15:0]. Both are saturating counters incremented on sideband_wen and dropped respectively, and cleared by reset.
  - Adds input stat_clear, a synchronous clear to 0; stat_clear has priority over a same-cycle increment.
- Undefined: these ports and counters do not exist.

Decomposition:
- Shared package/header: AXIS_DEST_WIDTH, frame_wdata field offsets (LAST_BIT=16), sideband field offsets (shared with the requester), and the state encoding localparams.
- One sub-module is natural: frame_writer_stats (the saturating counter pair), instantiated only under FRAME_WRITER_STATS_EN.

Test Plan:
- Accepted frame: frame_wptr=0x010; words 0xA000..0xA004 (tlast on the last); decision drop=0, dest=3 at word 2. Required response: 5 frame_wen; scan_payload high from the cycle after the decision to tlast; one sideband_wen with end_ptr=0x015, dest=3.
- Early drop: decision drop=1 at word 1 of an 8-word frame starting at 0x020. Required response: 1 frame_wen; 7 words drained; frame_wrst with frame_rst_wptr=0x020; dropped pulse; no sideband_wen.
- Late decision: 3-word frame ends before the decision; decision arrives 4 cycles later with drop=0. Required response: tready=0 in AWAIT; sideband push follows the decision.
- Backpressure: sideband_full held for 6 cycles at COMMIT. Required response: tready=0 and no push; push occurs on the first cycle after full deasserts; the next frame is then accepted.
- Wrap and oversize:
  - Frame starting at 0x7FE with 4 words: end_ptr=0x802.
  - MAX_FRAME_WORDS=8 with a 12-word frame: drain, rewind, dropped=1.
- Reset mid-PAYLOAD: assert reset at word 3. Required response: all outputs 0 the next cycle; no sideband_wen and no frame_wrst afterward.
